// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// control-transfer flush windows and data-memory wait-state freezing.
module hazard_sequencer #(
  parameter int BR_STALL_CYCLES = 2,
  parameter int REG_AW          = 5,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        state,
  output logic [15:0]       stall_count,
  output logic              mem_timeout
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0]  CTRL_LOAD = 4'(BR_STALL_CYCLES - 1);
  localparam logic [16:0] WAIT_MAX  = 17'(MEM_TIMEOUT);

  state_t      state_r, state_nxt_s;
  state_t      saved_r, saved_nxt_s;
  logic [3:0]  ctrl_cnt_r, ctrl_cnt_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic        timeout_r, timeout_nxt_s;
  logic [15:0] stall_cnt_r;

  logic        freeze_req_s, load_use_s, ctrl_s;
  logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, pipe_freeze_s;
  logic [16:0] wait_inc_s;

  assign freeze_req_s = mem_req & ~mem_ready;
  assign load_use_s   = id_valid & ex_memread & (ex_wreg != {REG_AW{1'b0}}) &
                        ((id_uses_rs & (id_rs == ex_wreg)) |
                         (id_uses_rt & (id_rt == ex_wreg)));
  assign ctrl_s       = id_valid & (id_branch | id_jump);
  assign wait_inc_s   = {1'b0, wait_cnt_r} + 17'd1;

  // Next-state, counter and output decode for the sequencer FSM
  always_comb begin
    state_nxt_s    = state_r;
    saved_nxt_s    = saved_r;
    ctrl_cnt_nxt_s = ctrl_cnt_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_nxt_s  = timeout_r;
    pc_write_s     = 1'b0;
    ifid_write_s   = 1'b0;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    pipe_freeze_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (freeze_req_s) begin
          pipe_freeze_s = 1'b1;
          saved_nxt_s   = ST_RUN;
          state_nxt_s   = ST_MEM_WAIT;
        end else if (load_use_s) begin
          idex_bubble_s = 1'b1;
        end else if (ctrl_s) begin
          ifid_write_s   = 1'b1;
          ifid_flush_s   = 1'b1;
          ctrl_cnt_nxt_s = CTRL_LOAD;
          state_nxt_s    = ST_CTRL_WAIT;
        end else begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      end
      ST_CTRL_WAIT: begin
        if (freeze_req_s) begin
          pipe_freeze_s = 1'b1;
          saved_nxt_s   = ST_CTRL_WAIT;
          state_nxt_s   = ST_MEM_WAIT;
        end else begin
          ifid_write_s = 1'b1;
          ifid_flush_s = 1'b1;
          pc_write_s   = (ctrl_cnt_r == 4'd0);
          if (ctrl_cnt_r == 4'd0) begin
            state_nxt_s = ST_RUN;
          end else begin
            ctrl_cnt_nxt_s = ctrl_cnt_r - 4'd1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          // Release: behave like the interrupted state, counter still held
          wait_cnt_nxt_s = 16'd0;
          state_nxt_s    = saved_r;
          ifid_write_s   = 1'b1;
          if (saved_r == ST_CTRL_WAIT) begin
            ifid_flush_s = 1'b1;
            pc_write_s   = (ctrl_cnt_r == 4'd0);
          end else begin
            pc_write_s = 1'b1;
          end
        end else begin
          pipe_freeze_s = 1'b1;
          if (wait_inc_s <= WAIT_MAX) begin
            wait_cnt_nxt_s = wait_inc_s[15:0];
          end else begin
            wait_cnt_nxt_s = wait_cnt_r;
          end
          if (wait_inc_s >= WAIT_MAX) begin
            timeout_nxt_s = 1'b1;
          end else begin
            timeout_nxt_s = timeout_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        saved_nxt_s = ST_RUN;
      end
    endcase
  end

  // FSM state, saved state, control/wait counters and sticky timeout
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= ST_RUN;
      saved_r    <= ST_RUN;
      ctrl_cnt_r <= 4'd0;
      wait_cnt_r <= 16'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      saved_r    <= saved_nxt_s;
      ctrl_cnt_r <= ctrl_cnt_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC was held
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_write_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_write    = pc_write_s    & ~RST;
  assign ifid_write  = ifid_write_s  & ~RST;
  assign ifid_flush  = ifid_flush_s  & ~RST;
  assign idex_bubble = idex_bubble_s & ~RST;
  assign pipe_freeze = pipe_freeze_s & ~RST;
  assign state       = state_r;
  assign stall_count = stall_cnt_r;
  assign mem_timeout = timeout_r;

endmodule
